// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, GF(2^8) arithmetic, S-boxes, byte permutations, FSM states.
// All functions are pure combinational helpers used by the inverse core.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4
  } aes_state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] acc;
    y   = gmul(a, a);
    acc = y;
    for (int k = 0; k < 6; k++) begin
      y   = gmul(y, y);
      acc = gmul(acc, y);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte b sits at row b%4, column b/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int r;
    int c;
    int src;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      r   = b % 4;
      c   = b / 4;
      src = r + 4 * ((c - r + 4) % 4);
      o[127-8*b -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_if.sv
// Start/valid handshake bundle between a requester and the AES inverse core.
interface aes_inv_if;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic         AES_busy;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  modport master (
    output AES_en, AES_data_in, AES_key_in,
    input  AES_busy, AES_data_out, AES_data_out_valid
  );

  modport slave (
    input  AES_en, AES_data_in, AES_key_in,
    output AES_busy, AES_data_out, AES_data_out_valid
  );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (bypassable).
// Zero latency; no flow control of its own.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] blk,
  input  logic [127:0] rk,
  input  logic         bypass_mix,
  output logic [127:0] result
);

  logic [127:0] sr;
  logic [127:0] sb;
  logic [127:0] ak;
  logic [127:0] mc;

  assign sr = inv_shift_rows(blk);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sb[127-8*i -: 8] = inv_sbox(sr[127-8*i -: 8]);
  end

  assign ak = sb ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
  end

  assign result = bypass_mix ? ak : mc;

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: 21 cycles from accept to valid, one inverse round per clock.
// Start requests are only sampled in IDLE; AES_en while busy is ignored (no queueing).
module aes_inv_top
  import aes_pkg::*;
#(
  parameter bit VALID_PULSE = 1'b1
) (
  input logic      AES_clk,
  input logic      AES_rst,
  aes_inv_if.slave bus
);

  aes_state_t   state;
  logic [127:0] ct;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] data_out;
  logic [3:0]   rnd;
  logic         busy;
  logic         out_vld;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  sw_in;
  logic [31:0]  sw_out;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [127:0] round_res;

  // Forward expansion rotates w3; the inverse step needs the previous w3, which is w3^w2.
  assign {w0, w1, w2, w3} = rk;
  assign sw_in  = (state == KEXP) ? w3 : (w3 ^ w2);
  assign sw_out = sub_word(rot_word(sw_in)) ^ {rcon(rnd), 24'h0};

  assign f0 = w0 ^ sw_out;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign rk_fwd = {f0, f1, f2, f3};
  assign rk_inv = {w0 ^ sw_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  aes_inv_round u_round (
    .blk        (st),
    .rk         (rk),
    .bypass_mix (state == FINAL),
    .result     (round_res)
  );

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state    <= IDLE;
      ct       <= '0;
      st       <= '0;
      rk       <= '0;
      rnd      <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      if (VALID_PULSE) out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.AES_en) begin
            ct    <= bus.AES_data_in;
            rk    <= bus.AES_key_in;
            rnd   <= 4'd1;
            busy  <= 1'b1;
            state <= KEXP;
            if (!VALID_PULSE) out_vld <= 1'b0;
          end
        end
        KEXP: begin
          rk <= rk_fwd;
          if (rnd == NR) state <= INIT;
          else           rnd   <= rnd + 4'd1;
        end
        INIT: begin
          st    <= ct ^ rk;
          rk    <= rk_inv;
          rnd   <= rnd - 4'd1;
          state <= ROUND;
        end
        ROUND: begin
          st  <= round_res;
          rk  <= rk_inv;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) state <= FINAL;
        end
        FINAL: begin
          data_out <= round_res;
          out_vld  <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.AES_busy           = busy;
  assign bus.AES_data_out       = data_out;
  assign bus.AES_data_out_valid = out_vld;

endmodule
